uart_report_fmt: RTL and testbench

Parametrised successor to the fixed 13-channel UART reporter. Once per report period, or on a manual trigger, it snapshots all ADC channel readings and emits one ASCII line per enabled channel to the UART transmitter over a valid/ready byte handshake. It sits between the ADC/BCD conversion stage and `uart_tx`. It adds three things the fixed reporter lacks:
- a per-channel enable mask;
- snapshot-consistent frames;
- real backpressure, replacing a blind tick.

---
 rtl/uart_report_fmt.sv | 163 ++++++++++++++++
 tb/tb_uart_report_fmt.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_report_fmt.sv
// Periodic / triggered ADC reporter: snapshots all channels and streams one ASCII line per
// enabled channel ("V01 - 1234 V\n\r") to a UART transmitter over a valid/ready handshake.
module uart_report_fmt #(
  parameter int unsigned CHANNELS = 13,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PERIOD   = 65_000_000,
  parameter logic [7:0]  UNIT     = 8'h56
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*DIGITS*4-1:0] adc_in,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic                         trigger,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned AdcW = CHANNELS * DIGITS * 4;
  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CntW = $clog2(PERIOD);
  localparam int unsigned IdxW = 5;
  localparam int          Dig  = int'(DIGITS);
  localparam int          Last = Dig + 9;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [AdcW-1:0]   snap_adc_q, snap_adc_d;
  logic [CHANNELS-1:0] snap_en_q, snap_en_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              wrap;
  logic [CHANNELS-1:0] search_mask;
  int                search_from;
  int                next_ch;
  logic              found;

  // Character idx of the line for channel ch (0-based), digits taken from adc.
  function automatic logic [7:0] char_at(input int ch, input int idx, input logic [AdcW-1:0] adc);
    logic [3:0] nib;
    int         num;
    logic [7:0] c;
    num = ch + 1;
    nib = 4'h0;
    c   = 8'h0D;
    if (idx == 0)                       c = UNIT;
    else if (idx == 1)                  c = 8'h30 + 8'(num / 10);
    else if (idx == 2)                  c = 8'h30 + 8'(num % 10);
    else if (idx == 3 || idx == 5)      c = 8'h20;
    else if (idx == 4)                  c = 8'h2D;
    else if (idx < Dig + 6) begin
      // MSD first: digit (idx-6) lives at nibble position DIGITS-1-(idx-6) of the channel
      nib = 4'(adc >> ((ch * Dig + Dig - 1 - (idx - 6)) * 4));
      c   = (nib > 4'd9) ? 8'h3F : {4'h3, nib};
    end
    else if (idx == Dig + 6)            c = 8'h20;
    else if (idx == Dig + 7)            c = UNIT;
    else if (idx == Dig + 8)            c = 8'h0A;
    else                                c = 8'h0D;
    return c;
  endfunction

  assign wrap = (cnt_q == CntW'(PERIOD - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CntW'(1);
  end

  // Lowest enabled channel at or above search_from; LOAD searches the live mask from 0.
  always_comb begin
    search_mask = (state_q == StLoad) ? ch_enable : snap_en_q;
    search_from = (state_q == StLoad) ? 0 : int'(ch_q) + 1;
    found       = 1'b0;
    next_ch     = 0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (1'(search_mask >> k) && k >= search_from) begin
        found   = 1'b1;
        next_ch = k;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | trigger | wrap;
    snap_adc_d = snap_adc_q;
    snap_en_d  = snap_en_q;
    ch_d       = ch_q;
    idx_d      = idx_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q) state_d = StLoad;
      end
      StLoad: begin
        snap_adc_d = adc_in;
        snap_en_d  = ch_enable;
        pending_d  = trigger | wrap;
        if (found) begin
          state_d = StSend;
          ch_d    = ChW'(next_ch);
          idx_d   = '0;
        end else begin
          state_d = StDone;
        end
      end
      StSend: begin
        if (tx_ready) begin
          if (int'(idx_q) < Last) begin
            idx_d = idx_q + IdxW'(1);
          end else if (found) begin
            ch_d  = ChW'(next_ch);
            idx_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Char index 0 is always UNIT, so the not-yet-loaded snapshot is never read here.
    tx_data_d = (state_d == StSend) ? char_at(int'(ch_d), int'(idx_d), snap_adc_q) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      snap_adc_q <= '0;
      snap_en_q  <= '0;
      ch_q       <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      snap_adc_q <= snap_adc_d;
      snap_en_q  <= snap_en_d;
      ch_q       <= ch_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == StSend);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_uart_report_fmt.sv
// Directed bench for uart_report_fmt: captures transferred bytes and compares whole frames
// against hand-written expected lines, plus handshake, latency and reset checks.
module tb_uart_report_fmt;

  localparam int Ch     = 13;
  localparam int Dig    = 4;
  localparam int Period = 300;

  logic                clk;
  logic                rst_n;
  logic [Ch*Dig*4-1:0] adc_in;
  logic [Ch-1:0]       ch_enable;
  logic                trigger;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                busy;
  logic                frame_done;

  uart_report_fmt #(
    .CHANNELS(Ch),
    .DIGITS  (Dig),
    .PERIOD  (Period),
    .UNIT    (8'h56)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_in    (adc_in),
    .ch_enable (ch_enable),
    .trigger   (trigger),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  byte unsigned cap_q[$];
  byte unsigned exp_q[$];
  bit           bp_mode = 0;
  int           done_cnt = 0;
  int           cyc = 0;
  int           first_x = 0;
  int           last_x = 0;
  bit           prev_stall = 0;
  bit           prev_xfer = 0;
  logic [7:0]   prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: a valid&ready seen here transfers at the next rising edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
      prev_xfer  = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (frame_done && cap_q.size() > 0) check("done_lag", prev_xfer, 1);
      if (frame_done) done_cnt++;
      prev_xfer = tx_valid && tx_ready;
      if (prev_xfer) begin
        if (cap_q.size() == 0) first_x = cyc;
        last_x = cyc;
        cap_q.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_capture();
    done_cnt = 0;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    trigger  = 1'b0;
    bp_mode  = 0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
  endtask

  task automatic pulse_trigger();
    @(posedge clk);
    #1 trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_cnt < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_cnt < n) check("timeout_done", done_cnt, n);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (cap_q.size() < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (cap_q.size() < n) check("timeout_bytes", cap_q.size(), n);
  endtask

  task automatic add_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    adc_in[k*16 +: 16] = v;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    adc_in    = '0;
    ch_enable = '0;
    trigger   = 1'b0;
    tx_ready  = 1'b1;
    #12;
    check("rst_data", tx_data, 8'h00);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);

    // Single channel at full rate, with request pipeline latency.
    do_reset();
    set_ch(0, 16'h1234);
    ch_enable = 13'h0001;
    add_line("V01 - 1234 V");
    pulse_trigger();
    @(negedge clk);
    check("t1_pend_busy", busy, 0);
    @(negedge clk);
    check("t1_load_busy", busy, 1);
    check("t1_load_valid", tx_valid, 0);
    @(negedge clk);
    check("t1_first_valid", tx_valid, 1);
    check("t1_first_data", tx_data, 8'h56);
    wait_done(1, 100);
    cmp_frame("t1");
    check("t1_span", last_x - first_x + 1, 14);
    @(negedge clk);
    check("t1_busy_after", busy, 0);

    // Mask skip and two-digit numbering.
    do_reset();
    adc_in = '0;
    set_ch(2, 16'h0509);
    set_ch(12, 16'h9999);
    ch_enable = 13'h1004;
    add_line("V03 - 0509 V");
    add_line("V13 - 9999 V");
    pulse_trigger();
    wait_done(1, 100);
    cmp_frame("t2");
    check("t2_span", last_x - first_x + 1, 28);

    // Same frame under random backpressure.
    do_reset();
    add_line("V03 - 0509 V");
    add_line("V13 - 9999 V");
    bp_mode = 1;
    pulse_trigger();
    wait_done(1, 400);
    bp_mode  = 0;
    tx_ready = 1'b1;
    cmp_frame("t3");

    // Snapshot isolation and invalid BCD digits.
    do_reset();
    adc_in = '0;
    set_ch(0, 16'h1A2F);
    ch_enable = 13'h0001;
    add_line("V01 - 1?2? V");
    pulse_trigger();
    wait_bytes(3, 50);
    adc_in    = '0;
    ch_enable = '1;
    wait_done(1, 100);
    cmp_frame("t4");
    check("t4_frames", done_cnt, 1);

    // Empty mask: DONE at T+3 with no bytes.
    do_reset();
    ch_enable = '0;
    pulse_trigger();
    @(negedge clk);
    check("t5_pend_valid", tx_valid, 0);
    @(negedge clk);
    check("t5_load_busy", busy, 1);
    check("t5_load_valid", tx_valid, 0);
    @(negedge clk);
    check("t5_done", frame_done, 1);
    check("t5_done_valid", tx_valid, 0);
    @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_bytes", cap_q.size(), 0);

    // Two triggers during a frame merge into one extra frame.
    do_reset();
    adc_in = '0;
    set_ch(0, 16'h0042);
    ch_enable = 13'h0001;
    add_line("V01 - 0042 V");
    add_line("V01 - 0042 V");
    pulse_trigger();
    wait_bytes(3, 50);
    pulse_trigger();
    wait_bytes(8, 50);
    pulse_trigger();
    wait_done(2, 200);
    repeat (40) @(negedge clk);
    #1;
    check("t6_frames", done_cnt, 2);
    cmp_frame("t6");

    // Asynchronous reset while byte 5 is presented, then a clean frame.
    do_reset();
    adc_in = '0;
    set_ch(0, 16'h1234);
    ch_enable = 13'h0001;
    pulse_trigger();
    wait_bytes(4, 50);
    @(posedge clk);
    #2;
    check("t7_pre_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", tx_valid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_data", tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    add_line("V01 - 1234 V");
    pulse_trigger();
    wait_done(1, 100);
    cmp_frame("t7");

    // Automatic start after the first counter wrap.
    rst_n = 1'b0;
    adc_in = '0;
    set_ch(0, 16'h0007);
    ch_enable = 13'h0001;
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    add_line("V01 - 0007 V");
    n = 0;
    while (!busy && n < 2 * Period) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t8_auto_start", n, Period + 1);
    wait_done(1, 100);
    cmp_frame("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
